// File: rtl/hi_lo_muldiv.sv
// hi_lo_muldiv: iterative mult/div unit holding the architectural HI/LO pair
module hi_lo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [1:0]       move,
  output logic [WIDTH-1:0] moveOut,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic neg_p, neg_r;
  logic sgn, dz;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0] add_sum, trial;
  assign sgn = ~op[0];
  assign dz = op[1] & (rt == '0);
  // a zero divisor keeps the raw dividend: the restoring loop then yields rem = rs and quotient = all ones
  assign rs_mag = (sgn & rs[WIDTH-1] & ~dz) ? -rs : rs;
  assign rt_mag = (sgn & rt[WIDTH-1]) ? -rt : rt;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
  assign acc_nx = op_q[1] ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                          : {add_sum, acc[WIDTH-1:1]};
  assign prod = neg_p ? -acc : acc;
  assign busy = state != IDLE;
  assign stall = busy & (start | mthi | mtlo | move == 2'b01 | move == 2'b10);
  assign moveOut = move == 2'b01 ? hi : move == 2'b10 ? lo : '0;
  // state register
  always_ff @(posedge CLK or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: IDLE -> CALC on start, CALC -> FIX after WIDTH iterations, FIX -> IDLE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? CALC : IDLE)
             : state == CALC ? (cnt == CW'(WIDTH - 1) ? FIX : CALC)
             : IDLE;
  end
  // operand capture, one iteration per CALC cycle, sign fix-up and HI/LO write in FIX
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      cnt <= '0;
      op_q <= '0;
      b <= '0;
      acc <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE && start) begin
        op_q <= op;
        b <= rt_mag;
        acc <= {{WIDTH{1'b0}}, rs_mag};
        neg_p <= sgn & (rs[WIDTH-1] ^ rt[WIDTH-1]) & ~dz;
        neg_r <= sgn & rs[WIDTH-1] & ~dz;
        cnt <= '0;
      end else if (state == IDLE) begin
        if (mthi) hi <= rs;
        if (mtlo) lo <= rs;
      end
      if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !op_q[1]) {hi, lo} <= prod;
      if (state == FIX && op_q[1]) begin
        lo <= neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
endmodule

// File: tb/tb_hi_lo_muldiv.sv
// tb_hi_lo_muldiv: table vectors, corner sequences and random ops against an arithmetic model
module tb_hi_lo_muldiv;
  logic CLK = 0, reset = 1, start = 0, mthi = 0, mtlo = 0;
  logic [1:0] op = 0, move = 0;
  logic [31:0] rs = 0, rt = 0;
  logic [31:0] moveOut, hi, lo;
  logic busy, done, stall;
  int pass_cnt = 0, total = 0;

  hi_lo_muldiv #(.WIDTH(32)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .mthi(mthi), .mtlo(mtlo), .move(move), .moveOut(moveOut),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    logic [1:0] op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;
  vec_t vecs[6];

  // reference: plain MIPS arithmetic on 64-bit integers, {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    longint x, y, q, r;
    logic [63:0] p, qq, rr;
    if (o == 2'd0) begin
      x = longint'($signed(a));
      y = longint'($signed(d));
      p = x * y;
      return p;
    end
    if (o == 2'd1) return {32'b0, a} * {32'b0, d};
    if (d == 0) return {a, 32'hffffffff};
    x = (o == 2'd2) ? longint'($signed(a)) : longint'({32'b0, a});
    y = (o == 2'd2) ? longint'($signed(d)) : longint'({32'b0, d});
    q = x / y;
    r = x % y;
    qq = q;
    rr = r;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d, input logic mh);
    start = 1; op = o; rs = a; rt = d; mthi = mh;
    @(negedge CLK);
    start = 0; mthi = 0;
  endtask

  task automatic finish_op(input string name, input int exp_n, input logic [63:0] exp);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check({name, " busy cycles"}, 64'(n), 64'(exp_n));
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    vecs[0] = '{"multu max", 2'd1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001};
    vecs[1] = '{"mult -3x5", 2'd0, 32'hfffffffd, 32'h00000005, 32'hffffffff, 32'hfffffff1};
    vecs[2] = '{"div -7/2", 2'd2, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd};
    vecs[3] = '{"divu 100/0", 2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hffffffff};
    vecs[4] = '{"div ovf", 2'd2, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000};
    vecs[5] = '{"div -5/0", 2'd2, 32'hfffffffb, 32'h00000000, 32'hfffffffb, 32'hffffffff};

    #2 reset = 0;
    #1;
    move = 2'b01;
    #1;
    check("rst busy", 64'(busy), 0);
    check("rst done", 64'(done), 0);
    check("rst stall", 64'(stall), 0);
    check("rst moveOut", 64'(moveOut), 0);
    check("rst hilo", {hi, lo}, 0);
    move = 0;
    @(negedge CLK) reset = 1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 0);
      finish_op(vecs[i].name, 33, {vecs[i].hi, vecs[i].lo});
      @(negedge CLK);
      check({vecs[i].name, " done pulse"}, 64'(done), 0);
    end

    rs = 32'h12345678; mthi = 1;
    @(negedge CLK);
    mthi = 0; mtlo = 1; rs = 32'h9abcdef0;
    @(negedge CLK);
    mtlo = 0; move = 2'b01;
    #1 check("mfhi", 64'(moveOut), 64'h12345678);
    check("idle stall", 64'(stall), 0);
    move = 2'b10;
    #1 check("mflo", 64'(moveOut), 64'h9abcdef0);
    move = 2'b01;
    issue(2'd1, 32'd3, 32'd4, 0);
    #1 check("busy stall", 64'(stall), 1);
    check("busy moveOut", 64'(moveOut), 64'h12345678);
    move = 0; start = 1; op = 2'd3; rs = 32'd1000; rt = 32'd7;
    #1 check("start stall", 64'(stall), 1);
    @(negedge CLK);
    start = 0;
    finish_op("ignored start", 32, 64'd12);
    @(negedge CLK);

    issue(2'd0, 32'h11111111, 32'd3, 1);
    finish_op("start+mthi", 33, 64'h00000000_33333333);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      logic [31:0] a, d;
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ($urandom_range(0, 7) == 0) d = 32'hffffffff;
      issue(o, a, d, 0);
      finish_op($sformatf("rand%0d op%0d %h %h", i, o, a, d), 33, model(o, a, d));
    end
    @(negedge CLK);
    check("b2b done pulse", 64'(done), 0);

    issue(2'd2, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge CLK);
    reset = 0;
    #1 check("midop rst hilo", {hi, lo}, 0);
    check("midop rst busy", 64'(busy), 0);
    @(negedge CLK) reset = 1;
    issue(2'd1, 32'd6, 32'd7, 0);
    finish_op("after rst 6x7", 33, 64'd42);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
